// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered N-input priority encoder with a valid/ready output.
// Captures the highest-priority active request into a binary index and a
// one-hot grant, and holds the result until the consumer accepts it.
// Optional feature macro: PRIO_ENC_ARB_ROUND_ROBIN_EN
//   undefined -> fixed priority, bit N-1 highest, bit 0 lowest
//   defined   -> rotating priority starting just below the last accepted index
module prio_enc_arb #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_multi
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_capture;
  logic           w_clear;

  logic           r_valid;
  logic [W-1:0]   r_idx;
  logic [N-1:0]   r_onehot;
  logic           r_multi;

  logic [W-1:0]   w_enc_idx;
  logic [N-1:0]   w_enc_oh;
  logic           w_enc_multi;

`ifdef PRIO_ENC_ARB_ROUND_ROBIN_EN
  logic [W-1:0]   r_last;
  logic [W-1:0]   w_ptr;
  logic           w_hs;

  // A capture on the accepting edge must already see the accepted index as
  // the new lowest-priority position, otherwise the same request would win twice.
  assign w_hs  = r_valid & out_ready;
  assign w_ptr = w_hs ? r_idx : r_last;

  // Rotating search: last-1, last-2, ..., 0, N-1, ..., last
  always_comb begin
    int   c;
    logic found;
    c         = 0;
    found     = 1'b0;
    w_enc_idx = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(w_ptr) + N - k) % N;
      if (!found && req[c]) begin
        found     = 1'b1;
        w_enc_idx = W'(c);
      end
    end
  end

  // Pointer follows each completed handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
    end else if (w_hs) begin
      r_last <= r_idx;
    end
  end
`else
  // Fixed priority: later (higher) bits overwrite lower ones
  always_comb begin
    w_enc_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_enc_idx = W'(i);
      end
    end
  end
`endif

  assign w_enc_oh    = {{(N-1){1'b0}}, 1'b1} << w_enc_idx;
  assign w_enc_multi = |(req & (req - {{(N-1){1'b0}}, 1'b1}));

  // Next-state and capture/clear decisions
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (|req) begin
            w_capture = 1'b1;
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output registers: load on capture, clear on release, otherwise frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_multi  <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_idx    <= w_enc_idx;
      r_onehot <= w_enc_oh;
      r_multi  <= w_enc_multi;
    end else if (w_clear) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_multi  <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_multi  = r_multi;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Testbench for prio_enc_arb with N=4: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_prio_enc_arb;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;
  logic         out_multi;

  int checks = 0;
  int errors = 0;

  // Model state: what the consumer should currently see
  bit m_valid;
  int m_idx;
  bit m_multi;
  int m_last;

  prio_enc_arb #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .out_multi  (out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef PRIO_ENC_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last - k + N) % N;
      if (r[c]) return c;
    end
    return 0;
`else
    // Highest set bit of a nonzero value
    return $clog2(int'(r) + 1) - 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] oh;
    oh = m_valid ? N'(1 << m_idx) : '0;
    check({tag, ".valid"},  64'(out_valid),  64'(m_valid));
    check({tag, ".idx"},    64'(out_idx),    64'(m_idx));
    check({tag, ".onehot"}, 64'(out_onehot), 64'(oh));
    check({tag, ".multi"},  64'(out_multi),  64'(m_multi));
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_multi = 1'b0;
    m_last  = 0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare
  task automatic tick(input string tag);
    logic [N-1:0] r;
    bit           rd;
    r  = req;
    rd = out_ready;
    @(posedge clk);
    if (m_valid && rd) m_last = m_idx;
    if (!m_valid || rd) begin
      if (r != '0) begin
        m_valid = 1'b1;
        m_idx   = pick(r, m_last);
        m_multi = ($countones(r) > 1);
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
        m_multi = 1'b0;
      end
    end
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag, {out_valid, out_idx, out_onehot, out_multi}, '0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    model_reset();
    #2;
    check("reset_outputs", {out_valid, out_idx, out_onehot, out_multi}, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    for (int i = 0; i < 5; i++) tick("idle");

    // Fixed priority capture, then stall with a changed request
    @(negedge clk);
    req = 4'b0110;
    tick("cap0110");
    check("cap0110.const", {out_valid, out_idx, out_onehot, out_multi}, {1'b1, 2'd2, 4'b0100, 1'b1});
    @(negedge clk);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall.const", {out_valid, out_idx, out_onehot, out_multi}, {1'b1, 2'd2, 4'b0100, 1'b1});
    end

    // Back-to-back grants
    @(negedge clk);
    out_ready = 1'b1;
    req = 4'b1000;
    tick("b2b0");
    check("b2b0.const", {out_valid, out_idx}, {1'b1, 2'd3});
    @(negedge clk);
    req = 4'b0010;
    tick("b2b1");
    check("b2b1.const", {out_valid, out_idx, out_onehot}, {1'b1, 2'd1, 4'b0010});
    @(negedge clk);
    req = 4'b0000;
    tick("b2b2");
    check("b2b2.const", {out_valid, out_idx, out_onehot}, {1'b0, 2'd0, 4'b0000});

    // Async reset while holding index 3
    @(negedge clk);
    req = 4'b1000;
    tick("pre_rst");
    out_ready = 1'b0;
    async_reset("async_rst");
    req = 4'b0001;
    tick("post_rst");
    check("post_rst.const", {out_valid, out_idx}, {1'b1, 2'd0});

    // ready with nothing valid is ignored
    @(negedge clk);
    out_ready = 1'b1;
    req = 4'b0000;
    tick("drain");
    tick("ready_idle");

`ifdef PRIO_ENC_ARB_ROUND_ROBIN_EN
    // Rotating grants with all requests held
    @(negedge clk);
    out_ready = 1'b0;
    async_reset("rr_rst");
    out_ready = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int e;
      e = (i == 4) ? 3 : 3 - i;
      tick("rr");
      check("rr.const", {out_valid, out_idx, out_multi}, {1'b1, 2'(e), 1'b1});
    end

    // Stalled grant must not move the pointer
    @(negedge clk);
    out_ready = 1'b0;
    async_reset("rr_stall_rst");
    tick("rr_stall_cap");
    for (int i = 0; i < 4; i++) begin
      tick("rr_stall");
      check("rr_stall.const", 64'(out_idx), 64'd3);
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick("rr_after_stall");
    check("rr_after_stall.const", 64'(out_idx), 64'd2);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
